// File: rtl/out_display_pkg.sv
// Shared definitions for the output-display stage: segment codes, the
// converter state encoding and the digit-position numbering used by the scan.
package out_display_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        CONV = 1'b1
    } state_t;

    localparam int NUM_DIGITS = 4;
    localparam int BCD_ITERS  = 8;

    // Segment bit order is {g,f,e,d,c,b,a}, active-high.
    localparam logic [6:0] SEG_BLANK = 7'h00;
    localparam logic [6:0] SEG_MINUS = 7'h40;
    localparam logic [6:0] SEG_DIGIT [0:9] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
        7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
    };

    // Digit positions, matching the bit positions in the anode enable.
    localparam logic [1:0] DIG_ONES  = 2'd0;
    localparam logic [1:0] DIG_TENS  = 2'd1;
    localparam logic [1:0] DIG_HUNDS = 2'd2;
    localparam logic [1:0] DIG_SIGN  = 2'd3;

    // Segment pattern of one BCD nibble; non-decimal codes show blank.
    function automatic logic [6:0] seg_of(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = SEG_DIGIT[0];
            4'd1:    s = SEG_DIGIT[1];
            4'd2:    s = SEG_DIGIT[2];
            4'd3:    s = SEG_DIGIT[3];
            4'd4:    s = SEG_DIGIT[4];
            4'd5:    s = SEG_DIGIT[5];
            4'd6:    s = SEG_DIGIT[6];
            4'd7:    s = SEG_DIGIT[7];
            4'd8:    s = SEG_DIGIT[8];
            4'd9:    s = SEG_DIGIT[9];
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential shift-add-3 (double-dabble) converter: 8-bit binary to three
// BCD digits, one iteration per clock. 'done' and 'bcd' are combinational and
// describe the iteration being performed this cycle, so the caller can latch
// the finished digits on the same edge that completes the conversion.
module bin2bcd_seq
    import out_display_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  bin,
    output logic        busy,
    output logic        done,
    output logic [11:0] bcd
);

    state_t      state;
    logic [2:0]  iter;
    logic [19:0] shreg;      // {hundreds, tens, ones, remaining binary}
    logic [11:0] adj;
    logic [19:0] shifted;

    // One double-dabble step: correct every nibble >= 5, then shift left.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        adj = shreg[19:8];
        for (int i = 0; i < 3; i++) begin
            if (shreg[8 + 4*i +: 4] >= 4'd5)
                adj[4*i +: 4] = shreg[8 + 4*i +: 4] + 4'd3;
        end
        shifted = {adj, shreg[7:0]} << 1;
    end

    assign busy = (state == CONV);
    assign done = (state == CONV) && (iter == 3'(BCD_ITERS - 1));
    assign bcd  = shifted[19:8];

    // Converter FSM: capture on start, then run exactly eight iterations.
    always_ff @(posedge clk) begin
        // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            state <= IDLE;
            iter  <= '0;
            shreg <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        shreg <= {12'd0, bin};
                        iter  <= '0;
                        state <= CONV;
                    end
                end
                CONV: begin
                    shreg <= shifted;
                    iter  <= iter + 3'd1;
                    if (done)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/out_display.sv
// Output-display stage: shows the CPU output byte in decimal on a 4-digit
// multiplexed 7-segment display, unsigned or two's complement. A conversion
// starts whenever {signed_mode, data} differs from the last converted value,
// and the finished digits are scanned one at a time by a refresh divider.
module out_display
    import out_display_pkg::*;
#(
    parameter int REFRESH_DIV = 1000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] data,
    input  logic       signed_mode,
    output logic [6:0] seg,
    output logic [3:0] an,
    output logic       busy
);

    localparam int               CNT_W   = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);

    logic        init;
    logic [8:0]  src_tag;
    logic [8:0]  shown_tag;
    logic        start;
    logic        neg_now;
    logic [7:0]  mag_now;
    logic        neg_cap;

    logic        conv_busy;
    logic        conv_done;
    logic [11:0] conv_bcd;

    logic [NUM_DIGITS-1:0][6:0] disp;
    logic [NUM_DIGITS-1:0][6:0] disp_next;
    logic [CNT_W-1:0]           refresh_cnt;
    logic [CNT_W-1:0]           refresh_next;
    logic [1:0]                 dig_idx;
    logic [1:0]                 dig_next;

    assign src_tag = {signed_mode, data};
    assign start   = !conv_busy && (init || (src_tag != shown_tag));
    assign busy    = conv_busy;

    // Sign and magnitude of the live input; -128 negates to 128 in 8 bits.
    always_comb begin
        neg_now = signed_mode & data[7];
        mag_now = neg_now ? (~data + 8'd1) : data;
    end

    bin2bcd_seq u_bin2bcd (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .bin   (mag_now),
        .busy  (conv_busy),
        .done  (conv_done),
        .bcd   (conv_bcd)
    );

    // Remember what is being converted, and the sign that goes with it.
    always_ff @(posedge clk) begin
        if (reset) begin
            init      <= 1'b1;
            shown_tag <= '0;
            neg_cap   <= 1'b0;
        end else if (start) begin
            init      <= 1'b0;
            shown_tag <= src_tag;
            neg_cap   <= neg_now;
        end
    end

    // Next display patterns, with leading-zero blanking applied at load time.
    always_comb begin
        disp_next = disp;
        if (conv_done) begin
            disp_next[DIG_ONES]  = seg_of(conv_bcd[3:0]);
            disp_next[DIG_TENS]  = (conv_bcd[11:4] == 8'd0) ? SEG_BLANK : seg_of(conv_bcd[7:4]);
            disp_next[DIG_HUNDS] = (conv_bcd[11:8] == 4'd0) ? SEG_BLANK : seg_of(conv_bcd[11:8]);
            disp_next[DIG_SIGN]  = neg_cap ? SEG_MINUS : SEG_BLANK;
        end
    end

    // Refresh divider: hold each digit REFRESH_DIV cycles, then advance.
    always_comb begin
        refresh_next = refresh_cnt + CNT_W'(1);
        dig_next     = dig_idx;
        if (refresh_cnt == CNT_MAX) begin
            refresh_next = '0;
            dig_next     = dig_idx + 2'd1;
        end
    end

    // Display, scan and output registers; seg/an are driven from next-state
    // values so fresh digits show on the edge that finishes a conversion.
    always_ff @(posedge clk) begin
        // NOTE: the display registers are reset because they drive a visible output; a blank display after reset is required.
        if (reset) begin
            disp        <= '0;
            refresh_cnt <= '0;
            dig_idx     <= DIG_ONES;
            an          <= 4'b0001;
            seg         <= SEG_BLANK;
        end else begin
            disp        <= disp_next;
            refresh_cnt <= refresh_next;
            dig_idx     <= dig_next;
            an          <= 4'b0001 << dig_next;
            seg         <= disp_next[dig_next];
        end
    end

endmodule

// File: tb/tb_out_display.sv
// Directed bench for out_display with a 4-cycle refresh divider.
module tb_out_display;

    typedef logic [3:0][6:0] pats_t;   // index 3 = sign ... index 0 = ones

    typedef struct {
        logic [7:0] d;
        logic       sm;
        pats_t      exp;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] data;
    logic       signed_mode;
    logic [6:0] seg;
    logic [3:0] an;
    logic       busy;

    int pass_cnt  = 0;
    int total_cnt = 0;

    out_display #(.REFRESH_DIV(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .data        (data),
        .signed_mode (signed_mode),
        .seg         (seg),
        .an          (an),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    // Pattern the display must show for the currently enabled digit.
    function automatic logic [6:0] pick(input pats_t p, input logic [3:0] a);
        logic [6:0] s;
        case (a)
            4'b0001: s = p[0];
            4'b0010: s = p[1];
            4'b0100: s = p[2];
            4'b1000: s = p[3];
            default: s = 7'h7F ^ p[0];
        endcase
        return s;
    endfunction

    // Capture all four scanned digit patterns (bounded waits).
    task automatic read_all(output pats_t got, output bit ok);
        logic [3:0] want;
        bit         found;
        ok  = 1'b1;
        got = '0;
        for (int k = 0; k < 4; k++) begin
            want  = 4'b0001 << k;
            found = 1'b0;
            for (int c = 0; c < 40; c++) begin
                if (an === want) begin
                    got[k] = seg;
                    found  = 1'b1;
                    break;
                end
                @(negedge clk);
            end
            if (!found) ok = 1'b0;
        end
    endtask

    // Count busy-high cycles of one conversion starting at the current negedge.
    task automatic wait_conv(output int hi, output bit ok);
        bit seen;
        hi   = 0;
        seen = 1'b0;
        ok   = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (busy === 1'b1) begin
                hi++;
                seen = 1'b1;
            end else if (seen) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        pats_t got;
        pats_t exp;
        bit    ok;
        int    hi;
        exp = {7'h00, 7'h00, 7'h00, 7'h3F};
        @(negedge clk);
        reset = 1'b1; data = 8'd0; signed_mode = 1'b0;
        repeat (3) @(negedge clk);
        total_cnt++;
        if (seg !== 7'h00 || an !== 4'b0001 || busy !== 1'b0)
            $display("FAIL reset_state: seg=%h an=%b busy=%b, want seg=00 an=0001 busy=0", seg, an, busy);
        else pass_cnt++;
        reset = 1'b0;
        @(negedge clk);
        total_cnt++;
        if (busy !== 1'b1 || seg !== 7'h00)
            $display("FAIL first_e0: busy=%b seg=%h, want busy=1 seg=00", busy, seg);
        else pass_cnt++;
        repeat (3) @(negedge clk);
        total_cnt++;
        if (seg !== 7'h00)
            $display("FAIL blank_during_conv: seg=%h, want 00", seg);
        else pass_cnt++;
        wait_conv(hi, ok);
        total_cnt++;
        if (!ok || hi != 5)
            $display("FAIL first_busy_len: remaining busy cycles=%0d ok=%0b, want 5", hi, ok);
        else pass_cnt++;
        read_all(got, ok);
        for (int k = 0; k < 4; k++) begin
            total_cnt++;
            if (!ok || got[k] !== exp[k])
                $display("FAIL reset_digit%0d: seg=%h ok=%0b, want %h", k, got[k], ok, exp[k]);
            else pass_cnt++;
        end
    endtask

    task automatic test_conversions;
        vec_t  vecs [7];
        pats_t got;
        bit    ok;
        int    hi;
        vecs[0] = '{8'hFF, 1'b0, {7'h00, 7'h5B, 7'h6D, 7'h6D}};  // 255
        vecs[1] = '{8'hFF, 1'b1, {7'h40, 7'h00, 7'h00, 7'h06}};  // -1
        vecs[2] = '{8'h80, 1'b1, {7'h40, 7'h06, 7'h5B, 7'h7F}};  // -128
        vecs[3] = '{8'h80, 1'b0, {7'h00, 7'h06, 7'h5B, 7'h7F}};  // 128
        vecs[4] = '{8'd7,  1'b0, {7'h00, 7'h00, 7'h00, 7'h07}};  // 7
        vecs[5] = '{8'd100,1'b0, {7'h00, 7'h06, 7'h3F, 7'h3F}};  // 100
        vecs[6] = '{8'hF6, 1'b1, {7'h40, 7'h00, 7'h06, 7'h3F}};  // -10
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            data = vecs[i].d; signed_mode = vecs[i].sm;
            wait_conv(hi, ok);
            total_cnt++;
            if (!ok || hi != 8)
                $display("FAIL conv%0d_busy_len: busy cycles=%0d ok=%0b, want 8", i, hi, ok);
            else pass_cnt++;
            read_all(got, ok);
            for (int k = 0; k < 4; k++) begin
                total_cnt++;
                if (!ok || got[k] !== vecs[i].exp[k])
                    $display("FAIL conv%0d_digit%0d: seg=%h ok=%0b, want %h", i, k, got[k], ok, vecs[i].exp[k]);
                else pass_cnt++;
            end
        end
    endtask

    task automatic test_mid_change;
        pats_t exp5;
        pats_t exp42;
        pats_t exp_prev;
        pats_t got;
        bit    ok;
        exp_prev = {7'h40, 7'h00, 7'h06, 7'h3F};                 // -10 from before
        exp5     = {7'h00, 7'h00, 7'h00, 7'h6D};
        exp42    = {7'h00, 7'h00, 7'h66, 7'h5B};
        @(negedge clk);
        data = 8'd5; signed_mode = 1'b0;
        repeat (3) @(negedge clk);                              // after E2
        data = 8'd42;
        repeat (5) @(negedge clk);                              // after E7
        total_cnt++;
        if (busy !== 1'b1 || seg !== pick(exp_prev, an))
            $display("FAIL mid_after_e7: busy=%b seg=%h an=%b, want busy=1 seg=%h", busy, seg, an, pick(exp_prev, an));
        else pass_cnt++;
        @(negedge clk);                                         // after E8
        total_cnt++;
        if (busy !== 1'b0 || seg !== pick(exp5, an))
            $display("FAIL mid_after_e8: busy=%b seg=%h an=%b, want busy=0 seg=%h", busy, seg, an, pick(exp5, an));
        else pass_cnt++;
        @(negedge clk);                                         // after new E0
        total_cnt++;
        if (busy !== 1'b1)
            $display("FAIL mid_new_e0: busy=%b, want 1", busy);
        else pass_cnt++;
        repeat (7) @(negedge clk);                              // after new E7
        total_cnt++;
        if (busy !== 1'b1 || seg !== pick(exp5, an))
            $display("FAIL mid_still_5: busy=%b seg=%h an=%b, want busy=1 seg=%h", busy, seg, an, pick(exp5, an));
        else pass_cnt++;
        @(negedge clk);                                         // after new E8
        total_cnt++;
        if (busy !== 1'b0 || seg !== pick(exp42, an))
            $display("FAIL mid_show_42: busy=%b seg=%h an=%b, want busy=0 seg=%h", busy, seg, an, pick(exp42, an));
        else pass_cnt++;
        read_all(got, ok);
        for (int k = 0; k < 4; k++) begin
            total_cnt++;
            if (!ok || got[k] !== exp42[k])
                $display("FAIL mid42_digit%0d: seg=%h ok=%0b, want %h", k, got[k], ok, exp42[k]);
            else pass_cnt++;
        end
    endtask

    task automatic test_scan;
        bit         found;
        logic [3:0] want;
        found = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (an === 4'b1000) begin found = 1'b1; break; end
        end
        if (found) begin
            found = 1'b0;
            for (int c = 0; c < 10; c++) begin
                @(negedge clk);
                if (an === 4'b0001) begin found = 1'b1; break; end
            end
        end
        total_cnt++;
        if (!found)
            $display("FAIL scan_sync: an=%b, never wrapped 1000->0001", an);
        else pass_cnt++;
        for (int step = 0; step < 5; step++) begin
            want = 4'b0001 << (step % 4);
            for (int c = 0; c < 4; c++) begin
                total_cnt++;
                if (an !== want)
                    $display("FAIL scan_step%0d_cyc%0d: an=%b, want %b", step, c, an, want);
                else pass_cnt++;
                @(negedge clk);
            end
        end
    endtask

    task automatic test_reset_mid_conv;
        pats_t exp;
        pats_t got;
        bit    ok;
        int    hi;
        exp = {7'h00, 7'h00, 7'h6F, 7'h6F};                     // 99
        @(negedge clk);
        data = 8'd99; signed_mode = 1'b0;
        repeat (3) @(negedge clk);                              // after E2
        total_cnt++;
        if (busy !== 1'b1)
            $display("FAIL rst_mid_busy: busy=%b, want 1", busy);
        else pass_cnt++;
        reset = 1'b1;
        @(negedge clk);
        total_cnt++;
        if (seg !== 7'h00 || an !== 4'b0001 || busy !== 1'b0)
            $display("FAIL rst_mid_state: seg=%h an=%b busy=%b, want seg=00 an=0001 busy=0", seg, an, busy);
        else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if (seg !== 7'h00 || an !== 4'b0001 || busy !== 1'b0)
            $display("FAIL rst_mid_hold: seg=%h an=%b busy=%b, want seg=00 an=0001 busy=0", seg, an, busy);
        else pass_cnt++;
        reset = 1'b0;
        @(negedge clk);
        total_cnt++;
        if (busy !== 1'b1 || seg !== 7'h00)
            $display("FAIL rst_reconv_start: busy=%b seg=%h, want busy=1 seg=00", busy, seg);
        else pass_cnt++;
        wait_conv(hi, ok);
        total_cnt++;
        if (!ok || hi != 8)
            $display("FAIL rst_reconv_len: busy cycles=%0d ok=%0b, want 8", hi, ok);
        else pass_cnt++;
        read_all(got, ok);
        for (int k = 0; k < 4; k++) begin
            total_cnt++;
            if (!ok || got[k] !== exp[k])
                $display("FAIL rst_digit%0d: seg=%h ok=%0b, want %h", k, got[k], ok, exp[k]);
            else pass_cnt++;
        end
    endtask

    initial begin
        reset       = 1'b1;
        data        = 8'd0;
        signed_mode = 1'b0;
        test_reset();
        test_conversions();
        test_mid_change();
        test_scan();
        test_reset_mid_conv();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/out_display.md
# out_display

Output-display stage that sits directly downstream of the CPU's output register. It takes the 8-bit `out` value and shows it in decimal on a 4-digit multiplexed 7-segment display, in unsigned (0..255) or two's-complement (-128..127) mode. A sequential shift-add-3 binary-to-BCD converter updates the digits whenever the value or mode changes, and a refresh divider scans the digits.

## Interface
- `REFRESH_DIV`, default 1000: clock cycles each digit stays enabled. Must be 1 or greater.
- `clk`  in  1  system clock; one clock domain only.
- `reset`  in  1  synchronous, active-high reset.
- `data`  in  8  value to display, driven from the CPU `out` port.
- `signed_mode`  in  1  1 means `data` is two's complement; 0 means unsigned.
- `seg`  out  7  segments {g,f,e,d,c,b,a}, active-high.
- `an`  out  4  one-hot digit enable, active-high. Bit 0 is ones, bit 1 tens, bit 2 hundreds, bit 3 sign.
- `busy`  out  1  high while a conversion is in progress.

## Operation
- Source tag: `{signed_mode, data}`. `shown_tag` holds the tag of the last conversion started.
- FSM states: IDLE and CONV.
- **IDLE → CONV**, when `init` is set or the source tag differs from `shown_tag`:
  - capture the magnitude and the sign;
  - store the tag in `shown_tag`;
  - clear `init`;
  - clear the iteration count.
- **Magnitude and sign:**
  - If `signed_mode` is 1 and `data[7]` is 1: `neg` = 1 and magnitude = `(~data + 1)` truncated to 8 bits. For 8'h80 this gives 128.
  - Otherwise: `neg` = 0 and magnitude = `data`.
- **CONV:** each cycle performs one double-dabble iteration:
  - add 3 to each BCD nibble that is 5 or greater;
  - then shift {bcd[11:0], mag} left by 1.
- After the 8th iteration the FSM returns to IDLE. On that same edge the hundreds, tens and ones digits and `neg` are loaded into the display registers.
- Changes to `data` or `signed_mode` during CONV are ignored. The tag compare in the next IDLE cycle starts a new conversion.
- **Digit contents:**
  - Ones: always shown.
  - Tens: blank when hundreds and tens are both 0.
  - Hundreds: blank when 0.
  - Sign: shows '-' (7'h40) when `neg` is 1, otherwise blank.
  - A blank digit drives `seg` = 7'h00.
- **Segment codes, digits 0–9:** 3F, 06, 5B, 4F, 66, 6D, 7D, 07, 7F, 6F.
- **Scan:**
  - The refresh counter counts 0..REFRESH_DIV-1 and then wraps to 0.
  - On the wrap, the digit index advances 0→1→2→3→0.
  - `an` = 1 << index.
  - `seg` is the pattern of the selected digit.

## Timing
- **Reset values:**
  - state IDLE, `init` = 1, `busy` = 0;
  - all display digits blank, `neg` = 0, so `seg` = 7'h00;
  - refresh counter = 0, digit index = 0, so `an` = 4'b0001;
  - `shown_tag` = 0.
- **Conversion latency:**
  - Edge E0 is the first edge in IDLE where the convert condition holds; it performs the capture.
  - Edges E1..E8 perform the 8 iterations.
  - New digits appear on `seg` after E8.
  - `busy` is 1 from after E0 through E8, then returns to 0.
- **First conversion:** after reset is released, the first edge with `reset` low is E0, because `init` is set.
- **Back-to-back:** the earliest E0 of the next conversion is the edge after E8.
- **Scan timing:** `an` and `seg` are registered. Each digit is enabled for exactly REFRESH_DIV cycles. With REFRESH_DIV = 1, the digit changes every cycle.
- **Reset mid-conversion:** aborts the conversion. All values return to their reset values and the display is blank. A fresh conversion starts after reset is released.
- **Reset precedence:** `reset` overrides everything else on the same edge.

## Structure
- Shared package `out_display_pkg`:
  - segment constants SEG_DIGIT[0:9], SEG_BLANK, SEG_MINUS;
  - state enum {IDLE, CONV};
  - digit-index constants.
- Sub-module `bin2bcd_seq`:
  - ports: clk, reset, start, bin[7:0], busy, done, bcd[11:0];
  - contains the 8-iteration shift-add-3 engine and the iteration counter.
- Top level `out_display` holds:
  - tag compare;
  - sign/magnitude;
  - display registers;
  - blanking;
  - refresh divider;
  - scan mux.

## Test plan
- **Reset and first conversion:**
  - Stimulus: reset high, then low, with `data` = 0 and `signed_mode` = 0.
  - Required response: `busy` high for 8 cycles. Afterwards, when `an` = 0001, `seg` = 3F. Digits 1–3 show 00.
- **Unsigned full scale:**
  - Stimulus: `data` = 255, unsigned.
  - Required response: ones/tens/hundreds = 6D/6D/5B; sign digit = 00.
- **Signed -1:**
  - Stimulus: `data` = 8'hFF, `signed_mode` = 1.
  - Required response: ones = 06; tens and hundreds = 00; sign = 40.
- **Signed -128 and mode toggle:**
  - Stimulus: `data` = 8'h80 signed; then `signed_mode` → 0 with `data` unchanged.
  - Required response: -128 (ones/tens/hundreds = 7F/5B/06, sign = 40); after the mode change, 128 with sign = 00.
- **Change mid-conversion:**
  - Stimulus: `data` 5 → 42 at E3.
  - Required response: 5 is shown after E8; the next edge is a new E0; 42 is shown 8 edges later.
- **Scan and reset mid-conversion:**
  - Stimulus: REFRESH_DIV = 4; then assert reset during CONV.
  - Required response: `an` steps 0001, 0010, 0100, 1000, 0001 every 4 cycles. After the reset, `seg` = 00, `an` = 0001, `busy` = 0, and a reconversion runs once reset is released.
